// File: rtl/adder_operand_packer_if.sv
// rtl/adder_operand_packer_if.sv - operand stream and packed-group bus between feeder, packer and adder_chains
// in_last is present only when ADDER_PACKER_LAST_EN is defined.
interface adder_operand_packer_if #(
    parameter int MIN_WIDTH = 8,
    parameter int ADDER_NUM = 4
);
    logic [MIN_WIDTH-1:0]           in_data;
    logic                           in_valid;
    logic                           in_ready;
`ifdef ADDER_PACKER_LAST_EN
    logic                           in_last;
`endif
    logic [MIN_WIDTH*ADDER_NUM-1:0] adder_din;
    logic                           din_valid;
    logic                           dout_valid;

    modport master (
`ifdef ADDER_PACKER_LAST_EN
        output in_last,
`endif
        output in_data, in_valid,
        input  in_ready, adder_din, din_valid, dout_valid
    );

    modport slave (
`ifdef ADDER_PACKER_LAST_EN
        input  in_last,
`endif
        input  in_data, in_valid,
        output in_ready, adder_din, din_valid, dout_valid
    );
endinterface

// File: rtl/adder_operand_packer.sv
// rtl/adder_operand_packer.sv - packs ADDER_NUM serial operands into one adder_chains input word
// Optional early group close via in_last when ADDER_PACKER_LAST_EN is defined.
module adder_operand_packer #(
    parameter int MIN_WIDTH     = 8,
    parameter int ADDER_NUM     = 4,
    parameter int CHAIN_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    adder_operand_packer_if.slave   bus
);
    localparam int IW = (ADDER_NUM > 1) ? $clog2(ADDER_NUM) : 1;
    localparam int CW = MIN_WIDTH * (ADDER_NUM - 1);
    localparam int DW = MIN_WIDTH * ADDER_NUM;
    localparam logic [IW-1:0] LAST_IDX = IW'(ADDER_NUM - 1);

    logic [IW-1:0] idx, idx_next;
    logic [CW-1:0] collect, collect_next;
    logic [DW-1:0] din_reg, din_next;
    logic [DW-1:0] packed_word;
    logic          din_valid_reg, din_valid_next;
    logic          accept;
    logic          close_early;

    // Downstream has no backpressure, so readiness only depends on reset.
    assign bus.in_ready = ~rst_n;
    assign accept       = bus.in_valid & bus.in_ready;

`ifdef ADDER_PACKER_LAST_EN
    assign close_early = bus.in_last;
`else
    assign close_early = 1'b0;
`endif

    // Lanes above idx are already zero because the buffer is cleared on every completion.
    always_comb begin
        packed_word = {{MIN_WIDTH{1'b0}}, collect};
        for (int i = 0; i < ADDER_NUM; i++) begin
            if (idx == IW'(i)) begin
                packed_word[i*MIN_WIDTH +: MIN_WIDTH] = bus.in_data;
            end
        end
    end

    always_comb begin
        idx_next       = idx;
        collect_next   = collect;
        din_next       = din_reg;
        din_valid_next = 1'b0;
        if (accept) begin
            if (idx == LAST_IDX || close_early) begin
                din_next       = packed_word;
                din_valid_next = 1'b1;
                idx_next       = '0;
                collect_next   = '0;
            end else begin
                collect_next = packed_word[CW-1:0];
                idx_next     = idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            idx           <= '0;
            collect       <= '0;
            din_reg       <= '0;
            din_valid_reg <= 1'b0;
        end else begin
            idx           <= idx_next;
            collect       <= collect_next;
            din_reg       <= din_next;
            din_valid_reg <= din_valid_next;
        end
    end

    assign bus.adder_din = din_reg;
    assign bus.din_valid = din_valid_reg;

    generate
        if (CHAIN_LATENCY == 0) begin : g_no_delay
            assign bus.dout_valid = din_valid_reg;
        end else begin : g_delay
            logic [CHAIN_LATENCY-1:0] delay_line;

            always_ff @(posedge clk) begin
                if (rst_n) begin
                    delay_line <= '0;
                end else begin
                    delay_line <= (delay_line << 1) | CHAIN_LATENCY'(din_valid_reg);
                end
            end

            assign bus.dout_valid = delay_line[CHAIN_LATENCY-1];
        end
    endgenerate
endmodule

// File: tb/tb_adder_operand_packer.sv
// tb/tb_adder_operand_packer.sv - scoreboard bench for adder_operand_packer
// Scenario tasks push expected words; a negedge monitor pops and compares.
module tb_adder_operand_packer;
    localparam int W   = 8;
    localparam int N   = 4;
    localparam int LAT = 2;

    logic clk;
    logic rst_n;

    adder_operand_packer_if #(.MIN_WIDTH(W), .ADDER_NUM(N)) bus ();

    adder_operand_packer #(.MIN_WIDTH(W), .ADDER_NUM(N), .CHAIN_LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [W*N-1:0] exp_q[$];
    int             dly_q[$];
    int             din_cycles[$];
    logic [W*N-1:0] prev_din;

    always @(negedge clk) begin
        logic [W*N-1:0] e;
        int t;
        cyc++;
        if (!rst_n) begin
            n_checks++;
            if (bus.din_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_din_valid cycle %0d: adder_din=%h, no group expected", cyc, bus.adder_din);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.adder_din !== e) begin
                        n_fail++;
                        $display("FAIL group_word: got %h, expected %h", bus.adder_din, e);
                    end
                end
                din_cycles.push_back(cyc);
                dly_q.push_back(cyc + LAT);
            end else if (bus.adder_din !== prev_din) begin
                n_fail++;
                $display("FAIL din_hold: adder_din changed to %h from %h without din_valid", bus.adder_din, prev_din);
            end
            if (bus.dout_valid === 1'b1) begin
                n_checks++;
                if (dly_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_dout_valid cycle %0d", cyc);
                end else begin
                    t = dly_q.pop_front();
                    if (cyc != t) begin
                        n_fail++;
                        $display("FAIL dout_latency: dout_valid at cycle %0d, expected cycle %0d", cyc, t);
                    end
                end
            end
        end
        prev_din = bus.adder_din;
    end

    task automatic drive_idle();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
`ifdef ADDER_PACKER_LAST_EN
        bus.in_last  = 1'b0;
`endif
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
`ifdef ADDER_PACKER_LAST_EN
        bus.in_last  = last;
`else
        if (last) $display("note: in_last requested without ADDER_PACKER_LAST_EN");
`endif
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (exp_q.size() != 0 || dly_q.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (exp_q.size() != 0 || dly_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d groups and %0d dout strobes still pending, expected 0", exp_q.size(), dly_q.size());
            exp_q.delete();
            dly_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
`ifdef ADDER_PACKER_LAST_EN
        bus.in_last  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks += 4;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 0", bus.in_ready); end
        if (bus.adder_din !== '0) begin n_fail++; $display("FAIL reset_adder_din: got %h, expected 0", bus.adder_din); end
        if (bus.din_valid !== 1'b0) begin n_fail++; $display("FAIL reset_din_valid: got %b, expected 0", bus.din_valid); end
        if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid: got %b, expected 0", bus.dout_valid); end
        @(posedge clk); #1;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b, expected 1", bus.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b0);
        exp_q.push_back(32'h04030201);
        send_beat(8'h04, 1'b0);
        drive_idle();
        drain();
    endtask

    task automatic test_gaps();
        send_beat(8'h10, 1'b0);
        drive_idle();
        send_beat(8'h20, 1'b0);
        drive_idle();
        drive_idle();
        send_beat(8'h30, 1'b0);
        exp_q.push_back(32'h40302010);
        send_beat(8'h40, 1'b0);
        drive_idle();
        drain();
    endtask

    task automatic test_back_to_back();
        din_cycles.delete();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back(32'hFFFFFFFF);
            send_beat(8'hFF, 1'b0);
        end
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) exp_q.push_back(32'h04030201);
            send_beat(8'(i), 1'b0);
        end
        drive_idle();
        drain();
        n_checks++;
        if (din_cycles.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_pulse_count: got %0d din_valid pulses, expected 2", din_cycles.size());
        end else if (din_cycles[1] - din_cycles[0] != N) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles, expected %0d", din_cycles[1] - din_cycles[0], N);
        end
    endtask

    task automatic test_reset_mid_group();
        send_beat(8'h55, 1'b0);
        send_beat(8'h66, 1'b0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_in_ready: got %b, expected 0", bus.in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        send_beat(8'hA1, 1'b0);
        send_beat(8'hA2, 1'b0);
        send_beat(8'hA3, 1'b0);
        exp_q.push_back(32'hA4A3A2A1);
        send_beat(8'hA4, 1'b0);
        drive_idle();
        drain();
    endtask

`ifdef ADDER_PACKER_LAST_EN
    task automatic test_last();
        send_beat(8'h11, 1'b0);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(32'h00002211);
        send_beat(8'h22, 1'b1);
        drive_idle();
        drain();
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b0);
        exp_q.push_back(32'h04030201);
        send_beat(8'h04, 1'b1);
        drive_idle();
        drain();
    endtask
`endif

    initial begin
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
`ifdef ADDER_PACKER_LAST_EN
        bus.in_last  = 1'b0;
`endif
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_reset_mid_group();
`ifdef ADDER_PACKER_LAST_EN
        test_last();
`endif
        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
